ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte per request to the keyboard, for example LED control (0xED) or reset (0xFF). It is the counterpart to `keyboard_interface`, which only receives. The block drives the shared PS2_CLK/PS2_DAT lines open-drain and runs on the divided system clock `clk`. While `busy` is high, the receiver must ignore line activity.

---
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle for ps2_host_tx.
//   tx_data  : byte to send to the PS/2 device
//   tx_valid : send request (accepted when tx_valid & tx_ready)
//   tx_ready : transmitter idle and able to accept
//   busy     : transfer in progress; the receiver must ignore the lines
//   tx_done  : one-cycle pulse on successful completion
//   tx_error : one-cycle pulse on failure
//   err_code : 00 none, 01 no device clock, 10 transfer timeout, 11 missing ACK
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte per request
// (e.g. 0xED LED control, 0xFF reset), driving PS2_CLK/PS2_DAT open-drain.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   host              : request/status bundle (ps2_host_tx_if.slave)
//   ps2_clk_in/dat_in : raw pin levels
//   ps2_clk_oe/dat_oe : 1 pulls the line low, 0 releases it
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int START_TIMEOUT  = 375000,
  parameter int XFER_TIMEOUT   = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int TMR_MAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = ($clog2(INHIBIT_CYCLES + 1) > 4) ? $clog2(INHIBIT_CYCLES + 1) : 4;
  localparam int FLT_W   = ($clog2(FILTER_LEN + 1) > 1) ? $clog2(FILTER_LEN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_RELEASE
  } state_t;

  // ---------------- input conditioning (index 0 = clk, 1 = dat) ----------------
  logic [1:0]       raw, sync1, sync2, filt;
  logic [FLT_W-1:0] flt_cnt [2];
  logic             clk_filt_q;
  logic             fall;

  assign raw = {ps2_dat_in, ps2_clk_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '1;
      sync2      <= '1;
      filt       <= '1;
      clk_filt_q <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      clk_filt_q <= filt[0];
      // A new level is taken only after FILTER_LEN consecutive differing samples.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
        end
      end
    end
  end

  assign fall = clk_filt_q & ~filt[0];

  // ---------------- transmit FSM ----------------
  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [9:0] shift, shift_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic       dat_oe_q, dat_oe_n;
  logic [1:0] err_code_q, err_code_n;
  logic       done_q, done_n;
  logic       error_q, error_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tmr        <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      dat_oe_q   <= 1'b0;
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tmr        <= tmr_n;
      shift      <= shift_n;
      bit_idx    <= bit_idx_n;
      dat_oe_q   <= dat_oe_n;
      err_code_q <= err_code_n;
      done_q     <= done_n;
      error_q    <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tmr_n      = tmr;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    dat_oe_n   = dat_oe_q;
    err_code_n = err_code_q;
    done_n     = 1'b0;
    error_n    = 1'b0;

    case (state)
      S_IDLE: begin
        dat_oe_n = 1'b0;
        if (host.tx_valid) begin
          // {stop, odd parity, data}, shifted out LSB first
          shift_n    = {1'b1, ~^host.tx_data, host.tx_data};
          err_code_n = 2'b00;
          cnt_n      = '0;
          state_n    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_n    = '0;
          dat_oe_n = 1'b1;                  // start bit
          state_n  = S_START;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_START: begin
        if (cnt == CNT_W'(15)) begin
          cnt_n     = '0;
          tmr_n     = TMR_W'(START_TIMEOUT);
          bit_idx_n = '0;
          state_n   = S_BITS;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_BITS, S_ACK, S_RELEASE: begin
        if (tmr == '0) begin
          // Timer holds at zero; no fall yet means the device never clocked.
          dat_oe_n   = 1'b0;
          err_code_n = (state == S_BITS && bit_idx == 4'd0) ? 2'b01 : 2'b10;
          error_n    = 1'b1;
          state_n    = S_IDLE;
        end else begin
          tmr_n = tmr - TMR_W'(1);
          if (state == S_BITS) begin
            if (fall) begin
              dat_oe_n  = ~shift[0];
              shift_n   = {1'b0, shift[9:1]};
              bit_idx_n = bit_idx + 4'd1;
              if (bit_idx == 4'd0) tmr_n = TMR_W'(XFER_TIMEOUT);
              if (bit_idx == 4'd9) state_n = S_ACK;
            end
          end else if (state == S_ACK) begin
            if (fall) begin
              if (!filt[1]) begin
                state_n = S_RELEASE;
              end else begin
                err_code_n = 2'b11;
                error_n    = 1'b1;
                state_n    = S_IDLE;
              end
            end
          end else begin
            if (filt[0] && filt[1]) begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign ps2_clk_oe    = (state == S_INHIBIT) || (state == S_START);
  assign ps2_dat_oe    = dat_oe_q;
  assign host.tx_ready = (state == S_IDLE);
  assign host.busy     = (state != S_IDLE);
  assign host.tx_done  = done_q;
  assign host.tx_error = error_q;
  assign host.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int unsigned INH  = 20;
  localparam int unsigned STO  = 400;
  localparam int unsigned XTO  = 600;
  localparam int unsigned FL   = 4;
  localparam int unsigned HALF = 20;   // device clock half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if host ();
  logic ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_in, ps2_dat_in;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch_low  = 1'b0;

  // Open-drain wired lines with pull-ups
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt  = 0;
  int unsigned both_cnt = 0;

  always @(posedge clk) begin
    if (host.tx_done) done_cnt++;
    if (host.tx_error) err_cnt++;
    if (host.tx_done && host.tx_error) both_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    host.tx_data  = d;
    host.tx_valid = 1'b1;
    tick;
    host.tx_valid = 1'b0;
  endtask

  // Device side: wait for the host to release the clock after inhibiting it.
  task automatic dev_wait_request(output int unsigned clk_cyc, output int unsigned dat_cyc,
                                  output logic ok);
    clk_cyc = 0;
    dat_cyc = 0;
    ok      = 1'b0;
    for (int unsigned i = 0; i < INH + 100; i++) begin
      if (ps2_clk_oe) begin
        clk_cyc++;
        if (ps2_dat_oe) dat_cyc++;
      end else if (clk_cyc > 0) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Device side: clock nfalls bits in (sampling on each rising edge), then
  // optionally an ACK edge: ack_mode 1 = pull dat low, 2 = leave dat high.
  task automatic dev_frame(input int unsigned nfalls, input int unsigned ack_mode,
                           input logic glitch, output logic [10:0] frame,
                           output int unsigned lat1);
    frame    = '0;
    lat1     = 0;
    frame[0] = ps2_dat_in;
    for (int unsigned i = 1; i <= nfalls; i++) begin
      repeat (HALF) tick;
      dev_clk_low = 1'b1;
      for (int unsigned k = 0; k < HALF; k++) begin
        tick;
        if (i == 1 && lat1 == 0 && !ps2_dat_oe) lat1 = k + 1;
      end
      frame[i]    = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (glitch && i == 3) begin
        repeat (5) tick;
        glitch_low = 1'b1;
        repeat (2) tick;
        glitch_low = 1'b0;
      end
    end
    if (ack_mode != 0) begin
      repeat (HALF) tick;
      if (ack_mode == 1) dev_dat_low = 1'b1;
      repeat (HALF / 2) tick;
      dev_clk_low = 1'b1;
      repeat (HALF) tick;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_for(input logic want_err, input int unsigned limit,
                          output int unsigned n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      if (want_err ? host.tx_error : host.tx_done) seen = 1'b1;
      else begin
        tick;
        n++;
      end
    end
  endtask

  initial begin
    logic [10:0]  frame;
    int unsigned  clk_cyc, dat_cyc, lat1, n;
    int unsigned  done0, err0;
    logic         ok, seen;

    host.tx_data  = 8'h00;
    host.tx_valid = 1'b0;

    // ---- reset ----
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_ready",   32'(host.tx_ready), 32'd1);
    check("rst_busy",    32'(host.busy),     32'd0);
    check("rst_clk_oe",  32'(ps2_clk_oe),    32'd0);
    check("rst_dat_oe",  32'(ps2_dat_oe),    32'd0);
    check("rst_done",    32'(host.tx_done),  32'd0);
    check("rst_error",   32'(host.tx_error), 32'd0);
    check("rst_errcode", 32'(host.err_code), 32'd0);

    // ---- 0xED, normal transfer with ACK ----
    done0 = done_cnt;
    start_tx(8'hED);
    check("ed_ready",  32'(host.tx_ready), 32'd0);
    check("ed_busy",   32'(host.busy),     32'd1);
    check("ed_clk_oe", 32'(ps2_clk_oe),    32'd1);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    check("ed_req_seen", 32'(ok),      32'd1);
    check("ed_clk_low",  32'(clk_cyc), 32'(INH + 16));
    check("ed_dat_lead", 32'(dat_cyc), 32'd16);
    dev_frame(10, 1, 1'b0, frame, lat1);
    // {stop=1, parity=1, 8'hED, start=0}
    check("ed_frame", 32'(frame), 32'h7DA);
    check("ed_latency", 32'(lat1 >= 1 && lat1 <= FL + 4), 32'd1);
    wait_for(1'b0, 100, n, seen);
    check("ed_done_seen", 32'(seen),          32'd1);
    check("ed_errcode",   32'(host.err_code), 32'd0);
    check("ed_no_error",  32'(host.tx_error), 32'd0);
    tick;
    check("ed_busy_drop", 32'(host.busy),       32'd0);
    check("ed_done_once", 32'(done_cnt - done0), 32'd1);

    // ---- 0x02 ----
    start_tx(8'h02);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    check("02_clk_low", 32'(clk_cyc), 32'(INH + 16));
    dev_frame(10, 1, 1'b0, frame, lat1);
    // {stop=1, parity=0, 8'h02, start=0}
    check("02_frame", 32'(frame), 32'h404);
    wait_for(1'b0, 100, n, seen);
    check("02_done_seen", 32'(seen), 32'd1);
    tick;

    // ---- no device clock ----
    start_tx(8'h81);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    wait_for(1'b1, STO + 50, n, seen);
    check("nodev_err_seen", 32'(seen),                      32'd1);
    check("nodev_timing",   32'(n >= STO && n <= STO + 2),  32'd1);
    check("nodev_errcode",  32'(host.err_code),             32'd1);
    check("nodev_clk_oe",   32'(ps2_clk_oe),                32'd0);
    check("nodev_dat_oe",   32'(ps2_dat_oe),                32'd0);
    check("nodev_ready",    32'(host.tx_ready),             32'd1);
    tick;

    // ---- ACK edge with dat left high ----
    err0 = err_cnt;
    start_tx(8'h3C);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    dev_frame(10, 2, 1'b0, frame, lat1);
    check("noack_err_pulse", 32'(err_cnt - err0),  32'd1);
    check("noack_errcode",   32'(host.err_code),   32'd3);
    check("noack_dat_oe",    32'(ps2_dat_oe),      32'd0);
    tick;

    // ---- device stops after 4 edges ----
    start_tx(8'h5A);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    dev_frame(4, 0, 1'b0, frame, lat1);
    wait_for(1'b1, XTO, n, seen);
    check("stall_err_seen", 32'(seen),          32'd1);
    check("stall_errcode",  32'(host.err_code), 32'd2);
    tick;

    // ---- request while busy is ignored; clock glitches are filtered ----
    done0 = done_cnt;
    start_tx(8'hA5);
    host.tx_data  = 8'h55;
    host.tx_valid = 1'b1;
    tick;
    host.tx_valid = 1'b0;
    check("busy_ready", 32'(host.tx_ready), 32'd0);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    dev_frame(10, 1, 1'b1, frame, lat1);
    // {stop=1, parity=1, 8'hA5, start=0}
    check("glitch_frame", 32'(frame), 32'h74A);
    wait_for(1'b0, 100, n, seen);
    check("glitch_done_seen", 32'(seen), 32'd1);
    repeat (5) tick;
    check("busy_not_queued", 32'(ps2_clk_oe),        32'd0);
    check("busy_one_done",   32'(done_cnt - done0),  32'd1);

    // ---- reset in the middle of BITS ----
    start_tx(8'h00);
    dev_wait_request(clk_cyc, dat_cyc, ok);
    dev_frame(3, 0, 1'b0, frame, lat1);
    check("mid_dat_oe_pre", 32'(ps2_dat_oe), 32'd1);
    done0 = done_cnt;
    err0  = err_cnt;
    rst = 1'b1;
    tick;
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("mid_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("mid_rst_busy",   32'(host.busy),  32'd0);
    rst = 1'b0;
    repeat (10) tick;
    check("mid_rst_no_done",  32'(done_cnt - done0), 32'd0);
    check("mid_rst_no_error", 32'(err_cnt - err0),   32'd0);

    check("never_done_and_error", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
